// File: rtl/kpn_codec_pkg.sv
// Shared types and sizing constants for the binary-to-BCD converter.
package kpn_codec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 5;
  localparam int OUT_DIGITS = 4;
  localparam int ITERATIONS = 16;

endpackage

// File: rtl/bin_to_bcd_module_if.sv
// Handshake and result bundle between the subtractor stage and the BCD converter.
interface bin_to_bcd_module_if;
  logic [15:0] entry_1;
  logic        wr_in;
  logic        rd;
  logic [15:0] output_1;
  logic        sign_1;
  logic        ovf_1;
  logic        wr;

  modport master (
    output entry_1, wr_in,
    input  rd, output_1, sign_1, ovf_1, wr
  );

  modport slave (
    input  entry_1, wr_in,
    output rd, output_1, sign_1, ovf_1, wr
  );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3_digit (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Adjust one digit so the following left shift carries correctly into the next digit.
  always_comb begin
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/bin_to_bcd_module.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble, 18 cycles per word).
// Define BIN_TO_BCD_SIGNED_EN to treat entry_1 as two's complement and report the sign.
module bin_to_bcd_module
  import kpn_codec_pkg::*;
#(
  parameter logic [15:0] SAT_CODE = 16'h9999
) (
  input  logic                clk,
  input  logic                rst_n,
  bin_to_bcd_module_if.slave  bus
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [15:0] out_q, out_d;
  logic        ovf_q, ovf_d;
  logic        wr_q, wr_d;
  logic [19:0] bcd_adj_s;
  logic [15:0] mag_s;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_in  (bcd_q[4*g +: 4]),
      .digit_out (bcd_adj_s[4*g +: 4])
    );
  end

`ifdef BIN_TO_BCD_SIGNED_EN
  logic sign_cap_q, sign_cap_d, sign_q, sign_d;

  // Two's complement magnitude; 16'h8000 maps to 32768, which later saturates.
  always_comb begin
    if (bus.entry_1[15]) begin
      mag_s = 16'd0 - bus.entry_1;
    end else begin
      mag_s = bus.entry_1;
    end
  end

  // Sign is captured with the word and published alongside the BCD result.
  always_comb begin
    sign_cap_d = sign_cap_q;
    sign_d     = sign_q;
    if (state_q == IDLE && bus.wr_in) begin
      sign_cap_d = bus.entry_1[15];
    end else if (state_q == DONE) begin
      sign_d = sign_cap_q;
    end else begin
      sign_d = sign_q;
    end
  end

  // Sign registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_cap_q <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      sign_cap_q <= sign_cap_d;
      sign_q     <= sign_d;
    end
  end

  assign bus.sign_1 = sign_q;
`else
  assign mag_s      = bus.entry_1;
  assign bus.sign_1 = 1'b0;
`endif

  // FSM next state, datapath and result update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wr_in) begin
          bin_d   = mag_s;
          bcd_d   = 20'd0;
          cnt_d   = 5'd0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj_s, bin_q} << 6'd1;
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'(ITERATIONS - 1)) begin
          state_d = DONE;
        end else begin
          state_d = CONV;
        end
      end
      DONE: begin
        wr_d    = 1'b1;
        state_d = IDLE;
        // Any ten-thousands digit means the value cannot be shown in four digits.
        if (bcd_q[BCD_DIGITS*4-1 : OUT_DIGITS*4] != 4'd0) begin
          out_d = SAT_CODE;
          ovf_d = 1'b1;
        end else begin
          out_d = bcd_q[OUT_DIGITS*4-1 : 0];
          ovf_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, scratch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      bin_q   <= 16'd0;
      bcd_q   <= 20'd0;
      out_q   <= 16'd0;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.rd       = (state_q == IDLE);
  assign bus.output_1 = out_q;
  assign bus.ovf_1    = ovf_q;
  assign bus.wr       = wr_q;

endmodule

// File: tb/tb_bin_to_bcd_module.sv
// Randomized scoreboard bench for bin_to_bcd_module; honours BIN_TO_BCD_SIGNED_EN.
module tb_bin_to_bcd_module;

  typedef struct {
    logic [15:0] out;
    logic        sign;
    logic        ovf;
    int          cap;
    int          done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic mon_rd_exp;
  logic [15:0] held_out = 16'h0000;
  logic        held_sign = 1'b0;
  logic        held_ovf = 1'b0;

  logic [15:0] edge_vals [0:9] = '{16'h0000, 16'h270F, 16'h2710, 16'hFFFF, 16'h8000,
                                   16'h7FFF, 16'hFFFB, 16'h9C40, 16'h0001, 16'h04D2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_module_if bus ();

  bin_to_bcd_module #(.SAT_CODE(16'h9999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference: plain decimal arithmetic on the magnitude.
  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    int   m;
    bit   neg;
`ifdef BIN_TO_BCD_SIGNED_EN
    neg = w[15];
    m   = neg ? (65536 - int'(w)) : int'(w);
`else
    neg = 1'b0;
    m   = int'(w);
`endif
    e.sign = neg;
    if (m > 9999) begin
      e.out = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.out = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
      e.ovf = 1'b0;
    end
    e.cap  = 0;
    e.done = 0;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle wr_in pulse; the model decides acceptance from its own timing.
  task automatic pulse(input logic [15:0] w);
    exp_t e;
    bit   acc;
    bus.entry_1 = w;
    bus.wr_in   = 1'b1;
    acc = (sbq.size() == 0) || (cyc + 1 > sbq[$].done);
    if (acc) begin
      e      = model(w);
      e.cap  = cyc + 1;
      e.done = cyc + 18;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.wr_in   = 1'b0;
    bus.entry_1 = 16'($urandom);
  endtask

  // Advance to the cycle in which the newest conversion strobes wr.
  task automatic wait_done();
    for (int i = 0; i < 40 && sbq.size() > 0 && cyc < sbq[$].done; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rd"},  32'(bus.rd), 32'd1);
    chk({tag, "_wr"},  32'(bus.wr), 32'd0);
    chk({tag, "_out"}, 32'(bus.output_1), 32'h0);
    chk({tag, "_sgn"}, 32'(bus.sign_1), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.ovf_1), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sbq.delete();
    held_out  = 16'h0000;
    held_sign = 1'b0;
    held_ovf  = 1'b0;
    #2;
    reset_checks("async_rst");
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on wr, rd expectation and output hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_rd_exp = 1'b1;
      foreach (sbq[i]) begin
        if (cyc >= sbq[i].cap && cyc < sbq[i].done) mon_rd_exp = 1'b0;
      end
      chk("rd", 32'(bus.rd), 32'(mon_rd_exp));
      if (bus.wr) begin
        if (sbq.size() == 0) begin
          chk("unexpected_wr", 32'(bus.wr), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("latency", 32'(cyc), 32'(mon_e.done));
          chk("output_1", 32'(bus.output_1), 32'(mon_e.out));
          chk("sign_1", 32'(bus.sign_1), 32'(mon_e.sign));
          chk("ovf_1", 32'(bus.ovf_1), 32'(mon_e.ovf));
          held_out  = mon_e.out;
          held_sign = mon_e.sign;
          held_ovf  = mon_e.ovf;
        end
      end else begin
        chk("hold_out", 32'(bus.output_1), 32'(held_out));
        chk("hold_sign", 32'(bus.sign_1), 32'(held_sign));
        chk("hold_ovf", 32'(bus.ovf_1), 32'(held_ovf));
        if (sbq.size() > 0 && cyc >= sbq[0].done) begin
          chk("missing_wr", 32'(bus.wr), 32'd1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish by 500000");
    $fatal(1);
  end

  initial begin
    bus.wr_in   = 1'b0;
    bus.entry_1 = 16'h0000;
    rst_n       = 1'b0;
    #2;
    reset_checks("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 1234, an ignored word during CONV, then back-to-back acceptance in the wr cycle.
    pulse(16'h04D2);
    idle(4);
    pulse(16'h0007);
    wait_done();
    pulse(16'h0007);
    wait_done();

    // Boundary words issued back to back.
    foreach (edge_vals[i]) begin
      pulse(edge_vals[i]);
      wait_done();
    end
    idle(20);

    // Reset in the middle of a conversion, then the same word again.
    pulse(16'h270F);
    idle(8);
    do_reset();
    idle(25);
    pulse(16'h270F);
    wait_done();
    idle(3);

    // Random words with random gaps; many land while busy and must be dropped.
    repeat (60) begin
      idle(int'($urandom_range(0, 20)));
      if ($urandom_range(0, 3) == 0) begin
        pulse(edge_vals[$urandom_range(0, 9)]);
      end else begin
        pulse(16'($urandom));
      end
    end

    idle(25);
    chk("drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
